// File: rtl/adder_sum_stage_pkg.sv
// Shared definitions for the adder sum stage: data width, buffer state encoding, flag bit indices.
// The optional flags output is enabled by defining ADDER_FLAGS_EN.
package adder_sum_stage_pkg;

  localparam int LEN_DATA = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 2;

endpackage

// File: rtl/adder_sum_stage_if.sv
// Handshake and data bundle between the last prefix stage, the sum stage and the result mux.
// The flags signal exists only when ADDER_FLAGS_EN is defined.
interface adder_sum_stage_if
  import adder_sum_stage_pkg::*;
#(
    parameter int WIDTH = LEN_DATA
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] g_grp;
    logic [WIDTH-1:0] p_grp;
    logic [WIDTH-1:0] p_bit;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_FLAGS_EN
    logic [2:0]       flags;
`endif

    modport master (
        output in_valid, g_grp, p_grp, p_bit, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef ADDER_FLAGS_EN
        , input flags
`endif
    );

    modport slave (
        input  in_valid, g_grp, p_grp, p_bit, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef ADDER_FLAGS_EN
        , output flags
`endif
    );

endinterface

// File: rtl/adder_sum_stage_sum_carry_calc.sv
// Combinational carry resolution and sum formation from group generate/propagate vectors.
// Flag outputs (ovf/neg/zero) exist only when ADDER_FLAGS_EN is defined.
module sum_carry_calc
  import adder_sum_stage_pkg::*;
#(
    parameter int WIDTH = LEN_DATA
) (
    input  logic [WIDTH-1:0] g_grp,
    input  logic [WIDTH-1:0] p_grp,
    input  logic [WIDTH-1:0] p_bit,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_FLAGS_EN
    , output logic [2:0]     flags
`endif
);

    // c[i+1] is the carry out of span [i:0]; every carry only needs cin, not its neighbour.
    logic [WIDTH:0] carry;

    assign carry[0]       = cin;
    assign carry[WIDTH:1] = g_grp | (p_grp & {WIDTH{cin}});
    assign sum            = p_bit ^ carry[WIDTH-1:0];
    assign cout           = carry[WIDTH];

`ifdef ADDER_FLAGS_EN
    always_comb begin
        flags            = 3'b000;
        flags[FLAG_OVF]  = carry[WIDTH] ^ carry[WIDTH-1];
        flags[FLAG_NEG]  = sum[WIDTH-1];
        flags[FLAG_ZERO] = (sum == '0);
    end
`endif

endmodule

// File: rtl/adder_sum_stage.sv
// Registered final adder stage: computes sum/cout (and flags with ADDER_FLAGS_EN) and holds
// results in a two-entry head/skid buffer behind a valid/ready handshake.
module adder_sum_stage
  import adder_sum_stage_pkg::*;
#(
    parameter int WIDTH = LEN_DATA
) (
    input  logic             clk,
    input  logic             rst,
    adder_sum_stage_if.slave bus
);

    buf_state_e       state, state_next;
    logic             in_ready_q, out_valid_q;
    logic             accept, pop;
    logic             load_head_new, load_head_skid, load_skid;
    logic [WIDTH-1:0] calc_sum, head_sum, skid_sum;
    logic             calc_cout, head_cout, skid_cout;
`ifdef ADDER_FLAGS_EN
    logic [2:0]       calc_flags, head_flags, skid_flags;
`endif

    sum_carry_calc #(.WIDTH(WIDTH)) u_calc (
        .g_grp (bus.g_grp),
        .p_grp (bus.p_grp),
        .p_bit (bus.p_bit),
        .cin   (bus.cin),
        .sum   (calc_sum),
        .cout  (calc_cout)
`ifdef ADDER_FLAGS_EN
        , .flags (calc_flags)
`endif
    );

    assign accept = bus.in_valid & in_ready_q;
    assign pop    = out_valid_q & bus.out_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next     = state;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next    = ST_ONE;
                    load_head_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_head_new = 1'b1;
                end else if (accept) begin
                    state_next = ST_TWO;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_next     = ST_ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            in_ready_q  <= (state_next != ST_TWO);
            out_valid_q <= (state_next != ST_EMPTY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_sum   <= '0;
            head_cout  <= 1'b0;
`ifdef ADDER_FLAGS_EN
            head_flags <= 3'b000;
`endif
        end else if (load_head_new) begin
            head_sum   <= calc_sum;
            head_cout  <= calc_cout;
`ifdef ADDER_FLAGS_EN
            head_flags <= calc_flags;
`endif
        end else if (load_head_skid) begin
            head_sum   <= skid_sum;
            head_cout  <= skid_cout;
`ifdef ADDER_FLAGS_EN
            head_flags <= skid_flags;
`endif
        end
    end

    // NOTE: the skid entry is storage only; it is never visible unless state says it is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_sum   <= calc_sum;
            skid_cout  <= calc_cout;
`ifdef ADDER_FLAGS_EN
            skid_flags <= calc_flags;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = head_sum;
    assign bus.cout      = head_cout;
`ifdef ADDER_FLAGS_EN
    assign bus.flags     = head_flags;
`endif

endmodule

// File: tb/tb_adder_sum_stage.sv
// Directed self-checking bench for adder_sum_stage (WIDTH=32); flag checks compile in with ADDER_FLAGS_EN.
module tb_adder_sum_stage;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passes = 0;

    adder_sum_stage_if #(.WIDTH(W)) bus ();

    adder_sum_stage #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural prefix model: group generate/propagate of span [i:0] from operands.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W-1:0] pb, g, p;
        logic gacc, pacc;
        pb   = a ^ b;
        gacc = 1'b0;
        pacc = 1'b1;
        for (int i = 0; i < W; i++) begin
            gacc = (a[i] & b[i]) | (pb[i] & gacc);
            pacc = pb[i] & pacc;
            g[i] = gacc;
            p[i] = pacc;
        end
        bus.g_grp = g;
        bus.p_grp = p;
        bus.p_bit = pb;
        bus.cin   = c;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive_op('0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid actual=%b expected=0", bus.out_valid); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready actual=%b expected=1", bus.in_ready); else passes++;
        checks++; if (bus.sum !== 32'h0) $display("FAIL reset_sum actual=%h expected=0", bus.sum); else passes++;
        checks++; if (bus.cout !== 1'b0) $display("FAIL reset_cout actual=%b expected=0", bus.cout); else passes++;
`ifdef ADDER_FLAGS_EN
        checks++; if (bus.flags !== 3'b000) $display("FAIL reset_flags actual=%b expected=000", bus.flags); else passes++;
`endif
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic         vc [3];
        logic [W-1:0] vs [3];
        logic         vo [3];
        logic [2:0]   vf [3];
        va[0] = 32'hFFFFFFFF; vb[0] = 32'h00000001; vc[0] = 1'b0; vs[0] = 32'h00000000; vo[0] = 1'b1; vf[0] = 3'b001;
        va[1] = 32'h7FFFFFFF; vb[1] = 32'h00000001; vc[1] = 1'b0; vs[1] = 32'h80000000; vo[1] = 1'b0; vf[1] = 3'b110;
        va[2] = 32'h00000005; vb[2] = 32'h0000000A; vc[2] = 1'b1; vs[2] = 32'h00000010; vo[2] = 1'b0; vf[2] = 3'b000;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_op(va[i], vb[i], vc[i]);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            checks++; if (bus.out_valid !== 1'b1) $display("FAIL vec%0d_out_valid actual=%b expected=1", i, bus.out_valid); else passes++;
            chk($sformatf("vec%0d_sum", i), bus.sum, vs[i]);
            checks++; if (bus.cout !== vo[i]) $display("FAIL vec%0d_cout actual=%b expected=%b", i, bus.cout, vo[i]); else passes++;
`ifdef ADDER_FLAGS_EN
            checks++; if (bus.flags !== vf[i]) $display("FAIL vec%0d_flags actual=%b expected=%b", i, bus.flags, vf[i]); else passes++;
`else
            if (vf[i] === 3'bxxx) $display("vector table corrupt");
`endif
            tick();
            checks++; if (bus.out_valid !== 1'b0) $display("FAIL vec%0d_drain actual=%b expected=0", i, bus.out_valid); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        drive_op(32'h1, 32'h2, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_one actual=%b expected=1", bus.in_ready); else passes++;
        chk("b2b_head0", bus.sum, 32'h3);
        drive_op(32'h10, 32'h20, 1'b0);
        tick();
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_ready_two actual=%b expected=0", bus.in_ready); else passes++;
        drive_op(32'h100, 32'h200, 1'b0);
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_ready_held actual=%b expected=0", bus.in_ready); else passes++;
        chk("b2b_stable", bus.sum, 32'h3);
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_release actual=%b expected=1", bus.in_ready); else passes++;
        chk("b2b_head1", bus.sum, 32'h30);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_valid2 actual=%b expected=1", bus.out_valid); else passes++;
        chk("b2b_head2", bus.sum, 32'h300);
        tick();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_empty actual=%b expected=0", bus.out_valid); else passes++;
    endtask

    task automatic test_throughput();
        bus.out_ready = 1'b1;
        drive_op(32'h0, 32'h0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            drive_op(32'h1111 * k, k, 1'b0);
            tick();
            checks++; if (bus.out_valid !== 1'b1) $display("FAIL tput%0d_valid actual=%b expected=1", k, bus.out_valid); else passes++;
            chk($sformatf("tput%0d_sum", k), bus.sum, 32'h1112 * k);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL tput_drain actual=%b expected=0", bus.out_valid); else passes++;
    endtask

    task automatic test_reset_in_two();
        bus.out_ready = 1'b0;
        drive_op(32'hA, 32'hB, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst2_full actual=%b expected=0", bus.in_ready); else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst2_out_valid actual=%b expected=0", bus.out_valid); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst2_in_ready actual=%b expected=1", bus.in_ready); else passes++;
        chk("rst2_sum", bus.sum, 32'h0);
        tick();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst2_no_ghost actual=%b expected=0", bus.out_valid); else passes++;
        bus.out_ready = 1'b1;
        drive_op(32'h12345678, 32'h11111111, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL rst2_after_valid actual=%b expected=1", bus.out_valid); else passes++;
        chk("rst2_after_sum", bus.sum, 32'h23456789);
        tick();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst2_after_drain actual=%b expected=0", bus.out_valid); else passes++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_throughput();
        test_reset_in_two();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/adder_sum_stage.md
# adder_sum_stage

Final, registered stage of the parallel-prefix adder. Consumes the group generate/propagate vectors from the last prefix stage plus the bitwise half-sum, and forms sum, carry-out and status flags. Result is held in a two-entry output buffer behind a valid/ready handshake, so the adder pipeline can stall without losing data. Sits directly downstream of the last prefix stage and upstream of the ALU result mux.

## Interface
- `WIDTH`, default `` `LEN_DATA `` (from `define/main.def.v`): operand width; must be ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream has a valid prefix result.
- `in_ready`  out  1  block can accept; registered, high when buffer holds < 2 entries.
- `g_grp`  in  WIDTH  group generate, bit i = generate of span [i:0].
- `p_grp`  in  WIDTH  group propagate, bit i = propagate of span [i:0].
- `p_bit`  in  WIDTH  bitwise a ^ b.
- `cin`  in  1  carry-in.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts head entry.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry out of bit WIDTH-1.
- `flags`  out  3  {ovf, neg, zero}; present only with `ADDER_FLAGS_EN`.

## Operation
- Carry: c[0] = cin; c[i+1] = g_grp[i] | (p_grp[i] & cin), for i = 0..WIDTH-1.
- sum[i] = p_bit[i] ^ c[i]; cout = c[WIDTH].
- ovf = c[WIDTH] ^ c[WIDTH-1] (signed overflow); neg = sum[WIDTH-1]; zero = (sum == 0).
- All computation is combinational on the input side; only the computed result is stored (no raw g/p stored).
- Buffer: two entries (head, skid). States EMPTY, ONE, TWO.
  - EMPTY: accept → ONE.
  - ONE: accept & !pop → TWO; pop & !accept → EMPTY; accept & pop → ONE (head replaced by new entry).
  - TWO: pop → ONE (skid moves to head); no accept possible.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Outputs always driven from head register; never combinational from inputs.
- in_ready = (state != TWO), registered with the state.
- Data stability: while out_valid & !out_ready, sum/cout/flags hold.

## Timing
- Reset (`rst` high at an edge): state EMPTY, out_valid 0, in_ready 1, sum 0, cout 0, flags 0. Any in-flight entries are discarded; an accept in the reset cycle is ignored.
- Latency: accept at edge N → out_valid high after edge N, result visible in cycle N+1.
- Throughput: 1 result/cycle while out_ready stays high.
- Stall: out_ready low for k ≥ 2 cycles → two entries captured, in_ready drops the cycle after the second accept.
- Release from TWO: in_ready rises the cycle after the first pop; order is strictly FIFO.
- Simultaneous accept and pop in ONE: new result at head in the next cycle, no bubble.
- in_valid low with out_ready high: buffer drains, one entry per cycle.

## Configuration
- `ADDER_FLAGS_EN` defined: `flags` port exists; ovf/neg/zero are computed, stored per entry, and reset to 0.
- Not defined: `flags` port and flag storage are removed; sum/cout/handshake unchanged.

## Structure
- Shared package/define file: `LEN_DATA`, buffer state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2), flag bit indices (ZERO=0, NEG=1, OVF=2).
- One sub-module: `sum_carry_calc`, purely combinational, (g_grp, p_grp, p_bit, cin) → (sum, cout, flags). Buffer/handshake logic stays in the top module.
- Bench derives g_grp/p_grp/p_bit from operands a, b with a behavioural model.

## Test plan
- WIDTH=32, a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 → next cycle sum=0x00000000, cout=1, zero=1, ovf=0, neg=0.
- a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1, neg=1, zero=0.
- a=0x00000005, b=0x0000000A, cin=1 → sum=0x00000010, cout=0, all flags 0.
- Back-to-back 3 operations with out_ready=0 → in_ready low after the 2nd accept, 3rd held upstream; raise out_ready → results delivered in order, one per cycle.
- State ONE, in_valid=1 and out_ready=1 in the same cycle for 8 cycles → 8 results delivered consecutively with no bubble.
- State TWO, assert rst for one cycle → out_valid=0, in_ready=1, sum=0 next cycle; a subsequent operation completes normally.
